// File: rtl/move_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_entry_ctrl
// Brief    : Cursor-driven from/to move entry with legality handshake, commit
//            pulse and side-to-move register control. Optional hold timeout
//            is built when MOVE_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module move_entry_ctrl #(
    parameter int SQ_W           = 6,
    parameter int MC_W           = 10,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Select,
    input  logic            Cancel,
    input  logic [SQ_W-1:0] Cursor,
    input  logic            Sq_Occupied,
    input  logic            Sq_White,
    input  logic            Turn_Q,
    input  logic            Legal_Valid,
    input  logic            Legal_Ok,
    output logic            Legal_Req,
    output logic [SQ_W-1:0] From_Sq,
    output logic [SQ_W-1:0] To_Sq,
    output logic            Holding,
    output logic            Commit,
    output logic            Illegal,
    output logic            Timeout,
    output logic            Turn_Load,
    output logic            Turn_D,
    output logic            Turn_Reset,
    output logic [MC_W-1:0] Move_Count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t          state_q;
    logic [SQ_W-1:0] from_sq_q;
    logic [SQ_W-1:0] to_sq_q;
    logic            holding_q;
    logic            legal_req_q;
    logic            commit_q;
    logic            illegal_q;
    logic            timeout_q;
    logic            turn_load_q;
    logic            turn_d_q;
    logic            turn_reset_q;
    logic            released_q;
    logic [MC_W-1:0] move_count_q;

    logic            w_own_piece;
    logic            w_timeout_hit;

    assign w_own_piece = Sq_Occupied && (Sq_White == Turn_Q);

`ifdef MOVE_TIMEOUT_EN
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [C_CNT_W-1:0] hold_cnt_q;

    // Held at zero outside HELD, so entering HELD (including the return from
    // a rejected move) always starts a fresh count; a Select restarts it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hold_cnt_q <= '0;
        end else if ((state_q != S_HELD) || Select) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    assign w_timeout_hit = (state_q == S_HELD) &&
                           (hold_cnt_q == C_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Constant-false expression: no timeout hardware exists in this build.
    assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            from_sq_q    <= '0;
            to_sq_q      <= '0;
            holding_q    <= 1'b0;
            legal_req_q  <= 1'b0;
            commit_q     <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            turn_load_q  <= 1'b0;
            turn_d_q     <= 1'b0;
            turn_reset_q <= 1'b1;
            released_q   <= 1'b0;
            move_count_q <= '0;
        end else begin
            // Turn_Reset covers the first full cycle after release as well.
            released_q   <= 1'b1;
            turn_reset_q <= ~released_q;

            commit_q     <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            turn_load_q  <= 1'b0;
            turn_d_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!Cancel && Select && w_own_piece) begin
                        from_sq_q <= Cursor;
                        holding_q <= 1'b1;
                        state_q   <= S_HELD;
                    end
                end

                S_HELD: begin
                    if (w_timeout_hit) begin
                        holding_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (Cancel) begin
                        holding_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (Select) begin
                        if (Cursor == from_sq_q) begin
                            holding_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else if (w_own_piece) begin
                            from_sq_q <= Cursor;
                        end else begin
                            to_sq_q     <= Cursor;
                            legal_req_q <= 1'b1;
                            state_q     <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    // A checker result takes priority over a same-cycle Cancel.
                    if (Legal_Valid) begin
                        legal_req_q <= 1'b0;
                        if (Legal_Ok) begin
                            commit_q     <= 1'b1;
                            turn_load_q  <= 1'b1;
                            turn_d_q     <= ~Turn_Q;
                            move_count_q <= move_count_q + 1'b1;
                            holding_q    <= 1'b0;
                            state_q      <= S_COMMIT;
                        end else begin
                            illegal_q <= 1'b1;
                            state_q   <= S_HELD;
                        end
                    end else if (Cancel) begin
                        legal_req_q <= 1'b0;
                        holding_q   <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                S_COMMIT: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Legal_Req  = legal_req_q;
    assign From_Sq    = from_sq_q;
    assign To_Sq      = to_sq_q;
    assign Holding    = holding_q;
    assign Commit     = commit_q;
    assign Illegal    = illegal_q;
    assign Timeout    = timeout_q;
    assign Turn_Load  = turn_load_q;
    assign Turn_D     = turn_d_q;
    assign Turn_Reset = turn_reset_q;
    assign Move_Count = move_count_q;

endmodule
`default_nettype wire

// File: doc/move_entry_ctrl.md
Name: move_entry_ctrl

Overview:
- Upstream controller for the board/turn state registers.
- Turns cursor-select presses into a from/to move and runs a request/response handshake with the legality checker.
- On a legal move, issues a one-cycle commit.
- Drives Load/D/Reset of the side-to-move register, an inverting-reset flip-flop that holds 1 = white to move.

Parameters:
SQ_W, 6, square index width; square = rank*8 + file, 0..63
MC_W, 10, move counter width
TIMEOUT_CYCLES, 50000000, hold timeout in cycles; used only with MOVE_TIMEOUT_EN

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
Select  in  1  one-cycle debounced select press
Cancel  in  1  one-cycle cancel press
Cursor  in  SQ_W  square under cursor
Sq_Occupied  in  1  piece present at Cursor (same-cycle lookup)
Sq_White  in  1  piece at Cursor is white
Turn_Q  in  1  side-to-move register output; 1 = white
Legal_Valid  in  1  legality checker result strobe
Legal_Ok  in  1  result; sampled only with Legal_Valid
Legal_Req  out  1  legality request, level
From_Sq  out  SQ_W  latched source square
To_Sq  out  SQ_W  latched destination square
Holding  out  1  source square selected
Commit  out  1  one-cycle board-update pulse
Illegal  out  1  one-cycle rejected-move pulse
Timeout  out  1  one-cycle auto-cancel pulse
Turn_Load  out  1  side-to-move register Load
Turn_D  out  1  side-to-move register D
Turn_Reset  out  1  side-to-move register Reset
Move_Count  out  MC_W  committed move count

Behaviour:
- Reset (Reset_n=0 at posedge):
  - state IDLE; From_Sq=To_Sq=0; Move_Count=0.
  - Holding, Legal_Req, Commit, Illegal, Timeout, Turn_Load, Turn_D all 0.
  - Turn_Reset=1.
- Turn_Reset is registered: stays 1 through the first cycle after Reset_n returns high, then 0.
- Turn_Load is never 1 while Turn_Reset=1.
- Reset mid-handshake drops Legal_Req on the next edge; any late Legal_Valid is ignored.
- All outputs are registered. Pulses (Commit, Illegal, Timeout, Turn_Load) are exactly one cycle wide.
- Own piece: Sq_Occupied=1 and Sq_White==Turn_Q.
- Cancel beats Select in the same cycle.
- State IDLE:
  - Select on own piece -> From_Sq<=Cursor, Holding<=1, go HELD.
  - Any other Select, and Cancel, are ignored.
- State HELD:
  - Cancel -> IDLE, Holding<=0.
  - Select with Cursor==From_Sq -> IDLE (deselect).
  - Select on a different own piece -> From_Sq<=Cursor, stay HELD.
  - Select on any other square -> To_Sq<=Cursor, Legal_Req<=1, go WAIT.
- State WAIT:
  - Legal_Req holds 1 until Legal_Valid is seen; Select is ignored.
  - Legal_Valid & Legal_Ok -> Legal_Req<=0, go COMMIT.
  - Legal_Valid & !Legal_Ok -> Legal_Req<=0, Illegal<=1, back to HELD with From_Sq kept.
  - Cancel with no Legal_Valid -> Legal_Req<=0, IDLE.
  - Legal_Valid and Cancel in the same cycle -> the result wins.
- State COMMIT (one cycle):
  - Commit=1, Turn_Load=1, Turn_D=~Turn_Q.
  - Move_Count<=Move_Count+1, wrapping at 2^MC_W.
  - Holding<=0, go IDLE.
- Legal_Valid outside WAIT is ignored.
- From_Sq and To_Sq stay stable from request through Commit.
- Latency: Select on the destination -> Legal_Req high at the next edge. Legal_Valid&Ok -> Commit/Turn_Load high one cycle later.

Optional Feature:
MOVE_TIMEOUT_EN
- Defined:
  - A hold counter clears on entry to HELD and on every Select while in HELD.
  - It counts each cycle in HELD. When it reaches TIMEOUT_CYCLES-1: go IDLE, Holding<=0, Timeout pulse.
  - A Select in the same cycle as the timeout is ignored.
  - The counter does not run in WAIT.
- Undefined: no counter is built and Timeout is tied 0.

Test Plan:
- Reset released, Turn_Q=1 -> Turn_Reset=1 for exactly 1 cycle after release, then 0; Move_Count=0; Holding=0.
- Turn_Q=1; Select Cursor=12 (white pawn); Select Cursor=28; Legal_Valid&Ok 3 cycles later -> From_Sq=12, To_Sq=28, Legal_Req high 3 cycles, then one Commit and one Turn_Load with Turn_D=0; Move_Count=1.
- Turn_Q=1; Select Cursor=52 (black piece) -> stays IDLE, Holding=0, no Legal_Req.
- HELD on 12; Select 13 (white piece) -> From_Sq=13, still HELD; Select 45; Legal_Valid with Ok=0 -> Illegal pulse, HELD, From_Sq=13.
- WAIT; Cancel and Legal_Valid&Ok in the same cycle -> Commit fires. Separately, Cancel alone in WAIT -> IDLE, Legal_Req=0, a later Legal_Valid has no effect.
- MOVE_TIMEOUT_EN with TIMEOUT_CYCLES=8; Select own piece, then idle -> Timeout pulse 8 cycles after entering HELD; Holding=0.
